frame_scheduler: RTL and testbench
==================================

FRAME_SCHEDULER -- requirements
Module: frame_scheduler

Interface
REQ-001 Parameter INST_NR, default 2, number of instance descriptors per frame.
REQ-002 Parameter MAX_VERT, default 8192, vertex memory depth; VA_W = $clog2(MAX_VERT).
REQ-003 Parameter MAX_TRI, default 8192, triangle memory depth; TA_W = $clog2(MAX_TRI).
REQ-004 Parameter MAX_TRI_CNT, default 256, max triangles per instance; TC_W = $clog2(MAX_TRI_CNT).
REQ-005 The block SHALL use a single clock and a synchronous, active-high reset:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
REQ-006 The block SHALL have the following remaining ports:
- desc_wr_en  in  1  descriptor write strobe.
- desc_wr_id  in  8  descriptor index.
- desc_wr_vert_base  in  VA_W  vertex base.
- desc_wr_tri_base  in  TA_W  triangle base.
- desc_wr_tri_count  in  TC_W  triangle count.
- rd_inst_id  in  8  instance currently read by the frame driver.
- curr_vert_base  out  VA_W  active vertex base for rd_inst_id.
- curr_tri_base  out  TA_W  active triangle base for rd_inst_id.
- curr_tri_count  out  TC_W  active triangle count for rd_inst_id.
- frame_start  in  1  one-cycle frame tick (vsync).
- draw_ready  out  1  permit to the frame driver.
- draw_done  in  1  frame driver: all instances emitted.
- pipe_idle  in  1  transform/raster pipeline empty.
- swap_req  out  1  framebuffer swap request.
- swap_ack  in  1  swap accepted.
- busy  out  1  state != IDLE.
- frame_cnt  out  16  completed frames.
- overrun_cnt  out  8  dropped frame ticks, saturating.

Function
REQ-007 FSM states: IDLE, COMMIT, RUN, DRAIN, SWAP.
REQ-008 IDLE: frame_start=1 -> COMMIT on the next edge.
REQ-009 COMMIT (1 cycle): all INST_NR shadow descriptors are copied to the active table; then -> RUN.
REQ-010 RUN: draw_ready = (state==RUN) && !draw_done, combinational; draw_done=1 -> DRAIN.
REQ-011 DRAIN: pipe_idle=1 -> SWAP; minimum 1 cycle in DRAIN.
REQ-012 SWAP: swap_req=1 (registered, asserted from SWAP entry); swap_ack=1 -> IDLE, swap_req=0 next cycle, frame_cnt+1 (wraps at 2^16).
REQ-013 frame_start=1 in any state other than IDLE: tick dropped, overrun_cnt+1, saturating at 255; no state change.
REQ-014 Descriptor writes target the shadow table only, with the write taking effect on the next edge.
REQ-015 A descriptor write with desc_wr_id >= INST_NR is ignored.
REQ-016 A descriptor write in the COMMIT cycle lands in the shadow table only; the commit copies pre-edge shadow values, so the write takes effect at the following frame.
REQ-017 curr_* outputs are a combinational lookup of the active table by rd_inst_id, with zero latency.
REQ-018 rd_inst_id >= INST_NR: curr_* = 0.
REQ-019 Active-table contents SHALL remain stable outside COMMIT.
REQ-020 A desc_wr_tri_count of 0 is stored unchanged; no clamping.

Reset
REQ-021 rst=1 at an edge: state IDLE; shadow and active tables all zero; swap_req=0; frame_cnt=0; overrun_cnt=0.
REQ-022 During reset, draw_ready=0 and busy=0.
REQ-023 Reset mid-frame (any state) SHALL abandon the frame without issuing swap_req.
REQ-024 Reset has priority over all inputs in the same cycle.

Structure
REQ-025 Typedef inst_desc_t {vert_base, tri_base, tri_count} SHALL be placed in buffer_id_pkg.
REQ-026 The FSM state enum SHALL be local to the module.
REQ-027 Sub-module inst_desc_table (shadow + active arrays, write port, commit strobe, combinational read port) SHALL hold descriptor storage; the FSM and counters reside in frame_scheduler.

Verification
REQ-028 Reset, then write id0={100,200,5} and id1={300,400,7}, then frame_start -> COMMIT next cycle; in RUN, rd_inst_id=1 gives curr_*={300,400,7}.
REQ-029 In RUN, draw_done=1 -> draw_ready=0 the same cycle; pipe_idle=0 for 10 cycles holds DRAIN; pipe_idle=1 -> swap_req=1; swap_ack=1 -> IDLE, frame_cnt=1.
REQ-030 frame_start pulsed 3 times during RUN -> overrun_cnt=3 and no restart; 300 such pulses -> overrun_cnt=255.
REQ-031 Write id0.tri_count=9 in the COMMIT cycle -> active value unchanged this frame; the next frame reads 9.
REQ-032 Write with desc_wr_id=5 when INST_NR=2 -> no table change; rd_inst_id=5 -> curr_*=0.
REQ-033 Assert rst in SWAP with swap_ack=0 -> next cycle IDLE, swap_req=0, tables zero, frame_cnt=0.

Source files
------------

// File: rtl/buffer_id_pkg.sv
// buffer_id_pkg: instance descriptor type shared by the frame scheduler and its descriptor table.
// Field widths follow the default memory depths.
package buffer_id_pkg;

    localparam int DEF_MAX_VERT    = 8192;
    localparam int DEF_MAX_TRI     = 8192;
    localparam int DEF_MAX_TRI_CNT = 256;
    localparam int DESC_VA_W       = $clog2(DEF_MAX_VERT);
    localparam int DESC_TA_W       = $clog2(DEF_MAX_TRI);
    localparam int DESC_TC_W       = $clog2(DEF_MAX_TRI_CNT);

    typedef struct packed {
        logic [DESC_VA_W-1:0] vert_base;
        logic [DESC_TA_W-1:0] tri_base;
        logic [DESC_TC_W-1:0] tri_count;
    } inst_desc_t;

    function automatic inst_desc_t make_desc(
        input logic [DESC_VA_W-1:0] v,
        input logic [DESC_TA_W-1:0] t,
        input logic [DESC_TC_W-1:0] c
    );
        make_desc = '{vert_base: v, tri_base: t, tri_count: c};
    endfunction

endpackage

// File: rtl/frame_scheduler_inst_desc_table.sv
// inst_desc_table: shadow/active descriptor tables with a write port, a commit strobe
// and a zero-latency read port of the active table.
module inst_desc_table
    import buffer_id_pkg::*;
#(
    parameter int INST_NR = 2,
    parameter int VA_W    = 13,
    parameter int TA_W    = 13,
    parameter int TC_W    = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [7:0]      wr_id,
    input  logic [VA_W-1:0] wr_vert_base,
    input  logic [TA_W-1:0] wr_tri_base,
    input  logic [TC_W-1:0] wr_tri_count,
    input  logic            commit,
    input  logic [7:0]      rd_id,
    output logic [VA_W-1:0] rd_vert_base,
    output logic [TA_W-1:0] rd_tri_base,
    output logic [TC_W-1:0] rd_tri_count
);

    localparam int         IW = INST_NR > 1 ? $clog2(INST_NR) : 1;
    localparam logic [8:0] NR = 9'(INST_NR);

    inst_desc_t shadow [INST_NR];
    inst_desc_t active [INST_NR];
    inst_desc_t rd_desc;
    logic       rd_hit;

    // Commit samples the pre-edge shadow, so a same-cycle write lands in the next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '{default: '0};
            active <= '{default: '0};
        end else begin
            if (commit)
                active <= shadow;
            if (wr_en && {1'b0, wr_id} < NR)
                shadow[wr_id[IW-1:0]] <= make_desc(DESC_VA_W'(wr_vert_base),
                                                   DESC_TA_W'(wr_tri_base),
                                                   DESC_TC_W'(wr_tri_count));
        end
    end

    always_comb begin
        rd_hit       = {1'b0, rd_id} < NR;
        rd_desc      = rd_hit ? active[rd_id[IW-1:0]] : '0;
        rd_vert_base = VA_W'(rd_desc.vert_base);
        rd_tri_base  = TA_W'(rd_desc.tri_base);
        rd_tri_count = TC_W'(rd_desc.tri_count);
    end

endmodule

// File: rtl/frame_scheduler.sv
// frame_scheduler: per-frame commit/run/drain/swap sequencer with overrun and frame counters.
module frame_scheduler
    import buffer_id_pkg::*;
#(
    parameter  int INST_NR     = 2,
    parameter  int MAX_VERT    = 8192,
    parameter  int MAX_TRI     = 8192,
    parameter  int MAX_TRI_CNT = 256,
    localparam int VA_W        = $clog2(MAX_VERT),
    localparam int TA_W        = $clog2(MAX_TRI),
    localparam int TC_W        = $clog2(MAX_TRI_CNT)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            desc_wr_en,
    input  logic [7:0]      desc_wr_id,
    input  logic [VA_W-1:0] desc_wr_vert_base,
    input  logic [TA_W-1:0] desc_wr_tri_base,
    input  logic [TC_W-1:0] desc_wr_tri_count,
    input  logic [7:0]      rd_inst_id,
    output logic [VA_W-1:0] curr_vert_base,
    output logic [TA_W-1:0] curr_tri_base,
    output logic [TC_W-1:0] curr_tri_count,
    input  logic            frame_start,
    output logic            draw_ready,
    input  logic            draw_done,
    input  logic            pipe_idle,
    output logic            swap_req,
    input  logic            swap_ack,
    output logic            busy,
    output logic [15:0]     frame_cnt,
    output logic [7:0]      overrun_cnt
);

    typedef enum logic [2:0] {IDLE, COMMIT, RUN, DRAIN, SWAP} state_t;

    state_t state;

    inst_desc_table #(
        .INST_NR(INST_NR),
        .VA_W   (VA_W),
        .TA_W   (TA_W),
        .TC_W   (TC_W)
    ) u_table (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (desc_wr_en),
        .wr_id       (desc_wr_id),
        .wr_vert_base(desc_wr_vert_base),
        .wr_tri_base (desc_wr_tri_base),
        .wr_tri_count(desc_wr_tri_count),
        .commit      (state == COMMIT),
        .rd_id       (rd_inst_id),
        .rd_vert_base(curr_vert_base),
        .rd_tri_base (curr_tri_base),
        .rd_tri_count(curr_tri_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            swap_req    <= 1'b0;
            frame_cnt   <= '0;
            overrun_cnt <= '0;
        end else begin
            // A tick outside IDLE is dropped and only counted.
            if (frame_start && state != IDLE && overrun_cnt != 8'hFF)
                overrun_cnt <= overrun_cnt + 8'd1;
            case (state)
                IDLE:    if (frame_start) state <= COMMIT;
                COMMIT:  state <= RUN;
                RUN:     if (draw_done) state <= DRAIN;
                DRAIN:   if (pipe_idle) begin
                    state    <= SWAP;
                    swap_req <= 1'b1;
                end
                SWAP:    if (swap_ack) begin
                    state     <= IDLE;
                    swap_req  <= 1'b0;
                    frame_cnt <= frame_cnt + 16'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy       = state != IDLE && !rst;
    assign draw_ready = state == RUN && !draw_done && !rst;

endmodule

// File: tb/tb_frame_scheduler.sv
// tb_frame_scheduler: directed + randomized frames checked against an array-based
// model of the shadow/active tables and the frame/overrun counters.
module tb_frame_scheduler;

    localparam int NR   = 2;
    localparam int VA_W = 13;
    localparam int TA_W = 13;
    localparam int TC_W = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            desc_wr_en = 1'b0;
    logic [7:0]      desc_wr_id = '0;
    logic [VA_W-1:0] desc_wr_vert_base = '0;
    logic [TA_W-1:0] desc_wr_tri_base = '0;
    logic [TC_W-1:0] desc_wr_tri_count = '0;
    logic [7:0]      rd_inst_id = '0;
    logic [VA_W-1:0] curr_vert_base;
    logic [TA_W-1:0] curr_tri_base;
    logic [TC_W-1:0] curr_tri_count;
    logic            frame_start = 1'b0;
    logic            draw_ready;
    logic            draw_done = 1'b0;
    logic            pipe_idle = 1'b0;
    logic            swap_req;
    logic            swap_ack = 1'b0;
    logic            busy;
    logic [15:0]     frame_cnt;
    logic [7:0]      overrun_cnt;

    frame_scheduler dut (
        .clk              (clk),
        .rst              (rst),
        .desc_wr_en       (desc_wr_en),
        .desc_wr_id       (desc_wr_id),
        .desc_wr_vert_base(desc_wr_vert_base),
        .desc_wr_tri_base (desc_wr_tri_base),
        .desc_wr_tri_count(desc_wr_tri_count),
        .rd_inst_id       (rd_inst_id),
        .curr_vert_base   (curr_vert_base),
        .curr_tri_base    (curr_tri_base),
        .curr_tri_count   (curr_tri_count),
        .frame_start      (frame_start),
        .draw_ready       (draw_ready),
        .draw_done        (draw_done),
        .pipe_idle        (pipe_idle),
        .swap_req         (swap_req),
        .swap_ack         (swap_ack),
        .busy             (busy),
        .frame_cnt        (frame_cnt),
        .overrun_cnt      (overrun_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int sh_v[NR], sh_t[NR], sh_c[NR];
    int ac_v[NR], ac_t[NR], ac_c[NR];
    int exp_frames = 0;
    int exp_over = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        for (int i = 0; i < NR; i++) begin
            sh_v[i] = 0; sh_t[i] = 0; sh_c[i] = 0;
            ac_v[i] = 0; ac_t[i] = 0; ac_c[i] = 0;
        end
        exp_frames = 0;
        exp_over = 0;
    endtask

    task automatic model_wr(input int id, input int v, input int t, input int c);
        if (id < NR) begin
            sh_v[id] = v; sh_t[id] = t; sh_c[id] = c;
        end
    endtask

    task automatic drive_wr(input int id, input int v, input int t, input int c);
        desc_wr_en        = 1'b1;
        desc_wr_id        = id[7:0];
        desc_wr_vert_base = v[VA_W-1:0];
        desc_wr_tri_base  = t[TA_W-1:0];
        desc_wr_tri_count = c[TC_W-1:0];
    endtask

    task automatic wr(input int id, input int v, input int t, input int c);
        drive_wr(id, v, t, c);
        tick;
        desc_wr_en = 1'b0;
        model_wr(id, v, t, c);
    endtask

    task automatic chk_curr(input int id);
        rd_inst_id = id[7:0];
        #1;
        chk($sformatf("vert_base[%0d]", id), 32'(curr_vert_base), id < NR ? ac_v[id] : 0);
        chk($sformatf("tri_base[%0d]", id), 32'(curr_tri_base), id < NR ? ac_t[id] : 0);
        chk($sformatf("tri_count[%0d]", id), 32'(curr_tri_count), id < NR ? ac_c[id] : 0);
    endtask

    task automatic pulses(input int n);
        repeat (n) begin
            frame_start = 1'b1;
            tick;
            exp_over = exp_over + 1 > 255 ? 255 : exp_over + 1;
        end
        frame_start = 1'b0;
    endtask

    task automatic run_frame(input bit cwr, input int id, input int v, input int t, input int c,
                             input bit rwr, input int n_over, input int drain_len,
                             input int ack_delay, input bit rst_in_swap);
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        chk("busy_commit", 32'(busy), 1);
        chk("ready_commit", 32'(draw_ready), 0);
        if (cwr) drive_wr(id, v, t, c);
        tick;
        desc_wr_en = 1'b0;
        for (int i = 0; i < NR; i++) begin
            ac_v[i] = sh_v[i]; ac_t[i] = sh_t[i]; ac_c[i] = sh_c[i];
        end
        if (cwr) model_wr(id, v, t, c);
        chk("ready_run", 32'(draw_ready), 1);
        chk_curr(0);
        chk_curr(1);
        tick;
        chk_curr(int'($urandom_range(2, 255)));
        pulses(n_over);
        chk("overrun_cnt", 32'(overrun_cnt), exp_over);
        chk("ready_after_ticks", 32'(draw_ready), 1);
        if (rwr) begin
            wr($urandom_range(0, 3), $urandom_range(0, 8191), $urandom_range(0, 8191),
               $urandom_range(0, 255));
            chk_curr(0);
            chk_curr(1);
        end
        draw_done = 1'b1;
        #1;
        chk("ready_on_done", 32'(draw_ready), 0);
        tick;
        draw_done = 1'b0;
        pipe_idle = 1'b0;
        repeat (drain_len) begin
            chk("swap_req_drain", 32'(swap_req), 0);
            chk("busy_drain", 32'(busy), 1);
            tick;
        end
        pipe_idle = 1'b1;
        tick;
        pipe_idle = 1'b0;
        chk("swap_req_set", 32'(swap_req), 1);
        if (rst_in_swap) begin
            rst = 1'b1;
            tick;
            model_reset;
            chk("rst_busy", 32'(busy), 0);
            chk("rst_ready", 32'(draw_ready), 0);
            chk("rst_swap_req", 32'(swap_req), 0);
            chk("rst_frame_cnt", 32'(frame_cnt), 0);
            chk("rst_overrun", 32'(overrun_cnt), 0);
            rst = 1'b0;
            chk_curr(0);
            chk_curr(1);
        end else begin
            repeat (ack_delay) begin
                tick;
                chk("swap_req_hold", 32'(swap_req), 1);
            end
            swap_ack = 1'b1;
            tick;
            swap_ack = 1'b0;
            exp_frames++;
            chk("swap_req_clear", 32'(swap_req), 0);
            chk("busy_idle", 32'(busy), 0);
            chk("frame_cnt", 32'(frame_cnt), exp_frames);
        end
    endtask

    initial begin
        model_reset;
        tick;
        tick;
        chk("reset_busy", 32'(busy), 0);
        chk("reset_ready", 32'(draw_ready), 0);
        chk("reset_swap_req", 32'(swap_req), 0);
        chk("reset_frame_cnt", 32'(frame_cnt), 0);
        chk("reset_overrun", 32'(overrun_cnt), 0);
        rst = 1'b0;
        chk_curr(0);
        chk_curr(1);
        tick;
        wr(0, 100, 200, 5);
        wr(1, 300, 400, 7);
        wr(5, 1234, 4321, 77);
        run_frame(1'b0, 0, 0, 0, 0, 1'b0, 3, 10, 2, 1'b0);
        chk_curr(5);
        run_frame(1'b1, 0, 100, 200, 9, 1'b0, 0, 0, 0, 1'b0);
        wr(1, 11, 22, 0);
        run_frame(1'b0, 0, 0, 0, 0, 1'b0, 300, 1, 0, 1'b0);
        for (int f = 0; f < 15; f++) begin
            repeat ($urandom_range(0, 3))
                wr($urandom_range(0, 7), $urandom_range(0, 8191), $urandom_range(0, 8191),
                   $urandom_range(0, 255));
            run_frame(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 8191),
                      $urandom_range(0, 8191), $urandom_range(0, 255), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 4), $urandom_range(0, 5), $urandom_range(0, 3), 1'b0);
        end
        run_frame(1'b0, 0, 0, 0, 0, 1'b0, 2, 3, 0, 1'b1);
        wr(0, 55, 66, 4);
        run_frame(1'b0, 0, 0, 0, 0, 1'b0, 0, 2, 1, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
